// File: rtl/hp_ctrl_pkg.sv
// Shared types and constants for the tank hit-point controller and its health-bar overlay.
package hp_ctrl_pkg;

    typedef enum logic [1:0] {
        S_ALIVE  = 2'd0,
        S_INVULN = 2'd1,
        S_DEAD   = 2'd2
    } state_t;

    localparam int HP_MAX_DEF = 5;

    localparam logic [11:0] COL_FULL  = 12'h0F0;
    localparam logic [11:0] COL_BLINK = 12'hFF0;
    localparam logic [11:0] COL_EMPTY = 12'h400;

    localparam int SEG_PITCH = 20;
    localparam int SEG_W     = 16;
    localparam int SEG_H     = 8;

endpackage

// File: rtl/hp_bar_draw.sv
// Combinational health-bar painter: one segment per hit point, full/blink/empty colours.
// Segments are decoded by constant range compares per segment, so no divider is needed.
module hp_bar_draw
    import hp_ctrl_pkg::*;
#(
    parameter int HP_MAX = HP_MAX_DEF,
    parameter int BAR_X  = 8,
    parameter int BAR_Y  = 8
) (
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [2:0]  hp,
    input  logic        blink,
    input  logic [11:0] rgb,
    output logic [11:0] pix
);

    logic [31:0] hx;
    logic [31:0] vx;
    logic        in_row;

    assign hx     = {21'd0, hcount};
    assign vx     = {22'd0, vcount};
    assign in_row = (vx >= 32'(BAR_Y)) && (vx <= 32'(BAR_Y + SEG_H - 1));

    always_comb begin
        pix = rgb;
        for (int i = 0; i < HP_MAX; i++) begin
            if (in_row && (hx >= 32'(BAR_X + SEG_PITCH * i)) &&
                (hx <= 32'(BAR_X + SEG_PITCH * i + SEG_W - 1))) begin
                pix = (i < int'(hp)) ? (blink ? COL_BLINK : COL_FULL) : COL_EMPTY;
            end
        end
    end

endmodule

// File: rtl/hp_ctrl.sv
// Tank hit-point FSM (ALIVE/INVULN/DEAD) with post-hit invulnerability and a health-bar overlay.
// Video path is a one-cycle register stage; rgb is replaced only inside bar segments outside blanking.
module hp_ctrl
    import hp_ctrl_pkg::*;
#(
    parameter int HP_MAX        = HP_MAX_DEF,
    parameter int INVULN_CYCLES = 65000000,
    parameter int BAR_X         = 8,
    parameter int BAR_Y         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic        restart,
    input  logic        hblnk,
    input  logic        vblnk,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [11:0] rgb,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [11:0] rgb_out,
    output logic [2:0]  hp,
    output logic        invuln,
    output logic        game_over
);

    localparam logic [2:0]  HP_FULL  = 3'(HP_MAX);
    localparam logic [31:0] CNT_LAST = 32'(INVULN_CYCLES - 1);

    state_t      st, st_n;
    logic [2:0]  hp_n;
    logic [31:0] cnt, cnt_n;
    logic        hit_q;
    logic        ev;
    logic        blink;
    logic        invuln_n;
    logic        game_over_n;
    logic [11:0] bar_pix;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_ALIVE;
            hp         <= HP_FULL;
            cnt        <= '0;
            hit_q      <= 1'b0;
            invuln     <= 1'b0;
            game_over  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            rgb_out    <= '0;
        end else begin
            st         <= st_n;
            hp         <= hp_n;
            cnt        <= cnt_n;
            hit_q      <= hit;
            invuln     <= invuln_n;
            game_over  <= game_over_n;
            hblnk_out  <= hblnk;
            vblnk_out  <= vblnk;
            hsync_out  <= hsync;
            vsync_out  <= vsync;
            hcount_out <= hcount;
            vcount_out <= vcount;
            rgb_out    <= (hblnk || vblnk) ? rgb : bar_pix;
        end
    end

    // Only a rising edge of hit counts, so a held hit cannot re-trigger after INVULN ends.
    always_comb begin
        ev    = hit && !hit_q;
        st_n  = st;
        hp_n  = hp;
        cnt_n = cnt;
        if (restart) begin
            st_n  = S_ALIVE;
            hp_n  = HP_FULL;
            cnt_n = '0;
        end else begin
            case (st)
                S_ALIVE: begin
                    if (ev) begin
                        if (hp > 3'd1) begin
                            hp_n  = hp - 3'd1;
                            st_n  = S_INVULN;
                            cnt_n = '0;
                        end else begin
                            hp_n = 3'd0;
                            st_n = S_DEAD;
                        end
                    end
                end
                S_INVULN: begin
                    if (cnt == CNT_LAST) begin
                        st_n  = S_ALIVE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                S_DEAD:  hp_n = 3'd0;
                default: st_n = S_ALIVE;
            endcase
        end
    end

    always_comb begin
        invuln_n    = (st_n == S_INVULN);
        game_over_n = (st_n == S_DEAD);
        blink       = (st == S_INVULN) && cnt[22];
    end

    hp_bar_draw #(
        .HP_MAX(HP_MAX),
        .BAR_X (BAR_X),
        .BAR_Y (BAR_Y)
    ) u_bar (
        .hcount(hcount),
        .vcount(vcount),
        .hp    (hp),
        .blink (blink),
        .rgb   (rgb),
        .pix   (bar_pix)
    );

endmodule

// File: tb/tb_hp_ctrl.sv
// Bench for hp_ctrl with a 16-cycle invulnerability window: FSM sequences plus a bar-overlay vector table.
module tb_hp_ctrl;

    logic        clk = 1'b0;
    logic        rst, hit, restart;
    logic        hblnk, vblnk, hsync, vsync;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [11:0] rgb;
    logic        hblnk_out, vblnk_out, hsync_out, vsync_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [11:0] rgb_out;
    logic [2:0]  hp;
    logic        invuln, game_over;

    hp_ctrl #(
        .HP_MAX(5), .INVULN_CYCLES(16), .BAR_X(8), .BAR_Y(8)
    ) dut (
        .clk(clk), .rst(rst), .hit(hit), .restart(restart),
        .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
        .hcount(hcount), .vcount(vcount), .rgb(rgb),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .rgb_out(rgb_out),
        .hp(hp), .invuln(invuln), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  hp;
        logic        inv;
        logic        go;
        logic        vid;
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [3:0]  tim;
    } exp_t;

    typedef struct {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];
    int   nvec = 0;
    int   nerr = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic push(input string nm, input int h, input bit inv, input bit go,
                        input bit vid, input logic [11:0] c, input logic [10:0] hc,
                        input logic [9:0] vc, input logic [3:0] tim);
        exp_t e;
        e.nm = nm; e.hp = 3'(h); e.inv = inv; e.go = go; e.vid = vid;
        e.rgb = c; e.hc = hc; e.vc = vc; e.tim = tim;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard: got empty queue, want one entry");
        end else begin
            e = sb.pop_front();
            cmp({e.nm, ".hp"}, 32'(hp), 32'(e.hp));
            cmp({e.nm, ".invuln"}, 32'(invuln), 32'(e.inv));
            cmp({e.nm, ".game_over"}, 32'(game_over), 32'(e.go));
            if (e.vid) begin
                cmp({e.nm, ".rgb_out"}, 32'(rgb_out), 32'(e.rgb));
                cmp({e.nm, ".hcount_out"}, 32'(hcount_out), 32'(e.hc));
                cmp({e.nm, ".vcount_out"}, 32'(vcount_out), 32'(e.vc));
                cmp({e.nm, ".timing_out"}, 32'({hblnk_out, vblnk_out, hsync_out, vsync_out}),
                    32'(e.tim));
            end
        end
    endtask

    task automatic step(input string nm, input int h, input bit inv, input bit go);
        push(nm, h, inv, go, 1'b0, '0, '0, '0, '0);
        tick();
    endtask

    // One-cycle hit from ALIVE, then ride out the full 16-cycle window.
    task automatic do_hit(input string nm, input int h);
        hit = 1'b1;
        step(nm, h, 1'b1, 1'b0);
        hit = 1'b0;
        for (int j = 0; j < 15; j++) step(nm, h, 1'b1, 1'b0);
        step({nm, "_end"}, h, 1'b0, 1'b0);
    endtask

    task automatic video_idle();
        hblnk = 0; vblnk = 0; hsync = 0; vsync = 0;
        hcount = '0; vcount = '0; rgb = '0;
    endtask

    task automatic video_busy();
        hblnk = 1; vblnk = 1; hsync = 1; vsync = 1;
        hcount = 11'd8; vcount = 10'd8; rgb = 12'hABC;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal;
    end

    initial begin
        tbl[0]  = '{11'd8,   10'd8,  1'b0, 1'b0, 12'h123, 12'h0F0};
        tbl[1]  = '{11'd68,  10'd8,  1'b0, 1'b0, 12'h123, 12'h400};
        tbl[2]  = '{11'd24,  10'd8,  1'b0, 1'b0, 12'hABC, 12'hABC};
        tbl[3]  = '{11'd8,   10'd8,  1'b0, 1'b1, 12'hABC, 12'hABC};
        tbl[4]  = '{11'd8,   10'd8,  1'b1, 1'b0, 12'h5A5, 12'h5A5};
        tbl[5]  = '{11'd23,  10'd15, 1'b0, 1'b0, 12'h111, 12'h0F0};
        tbl[6]  = '{11'd23,  10'd16, 1'b0, 1'b0, 12'h222, 12'h222};
        tbl[7]  = '{11'd7,   10'd8,  1'b0, 1'b0, 12'h333, 12'h333};
        tbl[8]  = '{11'd48,  10'd12, 1'b0, 1'b0, 12'h444, 12'h0F0};
        tbl[9]  = '{11'd63,  10'd8,  1'b0, 1'b0, 12'h555, 12'h0F0};
        tbl[10] = '{11'd64,  10'd8,  1'b0, 1'b0, 12'h666, 12'h666};
        tbl[11] = '{11'd88,  10'd8,  1'b0, 1'b0, 12'h777, 12'h400};
        tbl[12] = '{11'd103, 10'd15, 1'b0, 1'b0, 12'h888, 12'h400};
        tbl[13] = '{11'd104, 10'd8,  1'b0, 1'b0, 12'h999, 12'h999};
        tbl[14] = '{11'd28,  10'd7,  1'b0, 1'b0, 12'hAAA, 12'hAAA};

        // Reset with busy video inputs: everything downstream must read zero.
        rst = 1'b0; hit = 1'b0; restart = 1'b0;
        video_busy();
        push("reset0", 5, 0, 0, 1'b1, 12'h000, 11'd0, 10'd0, 4'b0000);
        tick();
        push("reset1", 5, 0, 0, 1'b1, 12'h000, 11'd0, 10'd0, 4'b0000);
        tick();
        rst = 1'b1;
        video_idle();
        step("idle", 5, 0, 0);

        // Single hit: 5 -> 4, invulnerable for exactly 16 cycles.
        do_hit("hit1", 4);

        // Pulses every 4 cycles: only the first and the first after the window count.
        restart = 1'b1;
        step("restart_a", 5, 0, 0);
        restart = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            hit = (i % 4 == 0);
            step("pulses", (i < 20) ? 4 : 3, (i < 16) || (i == 20), 0);
        end
        hit = 1'b0;
        for (int i = 0; i < 15; i++) step("pulses_wait", 3, 1, 0);
        step("pulses_end", 3, 0, 0);

        // Hit held high across the INVULN -> ALIVE transition decrements once.
        hit = 1'b1;
        for (int i = 0; i < 20; i++) step("held", 2, i < 16, 0);
        hit = 1'b0;
        step("held_rel", 2, 0, 0);

        // Five separated hits from full: down to 0 and game over, then hits ignored.
        restart = 1'b1;
        step("restart_b", 5, 0, 0);
        restart = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            hit = 1'b1;
            step("drain", k, k != 0, k == 0);
            hit = 1'b0;
            for (int j = 0; j < 16; j++) step("drain_wait", k, (k != 0) && (j < 15), k == 0);
        end
        for (int i = 0; i < 6; i++) begin
            hit = i[0];
            step("dead_hits", 0, 0, 1);
        end

        // Restart wins over a simultaneous hit in DEAD.
        hit = 1'b1; restart = 1'b1;
        step("restart_hit", 5, 0, 0);
        hit = 1'b0; restart = 1'b0;
        step("restart_hold", 5, 0, 0);

        // Bring hp to 3 and sweep the bar overlay table.
        do_hit("to4", 4);
        do_hit("to3", 3);
        for (int i = 0; i < 15; i++) begin
            hcount = tbl[i].hc; vcount = tbl[i].vc;
            hblnk = tbl[i].hb;  vblnk = tbl[i].vb;
            hsync = i[0];       vsync = i[1];
            rgb = tbl[i].rgb;
            push($sformatf("bar%0d", i), 3, 0, 0, 1'b1, tbl[i].exp, tbl[i].hc, tbl[i].vc,
                 {tbl[i].hb, tbl[i].vb, i[0], i[1]});
            tick();
        end
        video_idle();

        // Reset mid-INVULN at counter 7, then confirm a fresh full-length window.
        hit = 1'b1;
        step("r_hit", 2, 1, 0);
        hit = 1'b0;
        for (int i = 0; i < 7; i++) step("r_count", 2, 1, 0);
        rst = 1'b0;
        video_busy();
        push("r_mid", 5, 0, 0, 1'b1, 12'h000, 11'd0, 10'd0, 4'b0000);
        tick();
        rst = 1'b1;
        video_idle();
        step("r_after", 5, 0, 0);
        do_hit("r_post", 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
